// File: rtl/cpu_seq_pkg.sv
// Shared types and default widths for the CPU request sequencer.
package cpu_seq_pkg;

  localparam int unsigned ADDR_W_DEF = 14;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_FINISH  = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  // One table entry at the default widths; data is write data or expected read data.
  typedef struct packed {
    logic                  read_write;
    logic                  check;
    logic [ADDR_W_DEF-1:0] address;
    logic [DATA_W_DEF-1:0] data;
  } req_t;

endpackage

// File: rtl/cpu_seq_table.sv
// Request table: one synchronous write port, one asynchronous read port. Not reset.
module cpu_seq_table
  import cpu_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned ENTRY_W = 48
) (
  input  logic               clock,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_index,
  input  logic [ENTRY_W-1:0] wr_entry,
  input  logic [IDX_W-1:0]   rd_index,
  output logic [ENTRY_W-1:0] rd_entry
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Entry write from the load port
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_index] <= wr_entry;
    end
  end

  assign rd_entry = mem[rd_index];

endmodule

// File: rtl/cpu_request_sequencer.sv
// Replays a loaded table of read/write requests to the cache, one at a time,
// counting hits, misses and read-data mismatches, with a per-request watchdog.
module cpu_request_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [IDX_W-1:0]  load_index,
  input  logic              load_read_write,
  input  logic [ADDR_W-1:0] load_address,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_check,
  input  logic              start,
  input  logic [IDX_W:0]    req_count,
  output logic              req_valid,
  output logic              read_write,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic              done,
  input  logic              hit,
  input  logic [DATA_W-1:0] read_data,
  output logic              busy,
  output logic              finished,
  output logic              timed_out,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  mismatch_count
);

  localparam int unsigned WD_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned ENTRY_W = ADDR_W + DATA_W + 2;

  typedef struct packed {
    logic              read_write;
    logic              check;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W:0]    count;
  logic [WD_W-1:0]   wd;
  logic              cur_check;
  logic [DATA_W-1:0] cur_expect;

  logic              tbl_we_c;
  logic [IDX_W-1:0]  rd_idx_c;
  entry_t            ld_entry_c;
  entry_t            tbl_rd_c;
  entry_t            next_entry_c;
  logic [IDX_W:0]    clamp_cnt_c;
  logic              last_c;
  logic              accept_c;
  logic              mismatch_c;

  // Table access, next-entry selection (with same-cycle load forwarding) and completion decode
  always_comb begin
    ld_entry_c   = '{read_write: load_read_write, check: load_check,
                     address: load_address, data: load_data};
    tbl_we_c     = load_en && (state != S_ACTIVE);
    rd_idx_c     = (state == S_ACTIVE) ? IDX_W'(ptr + IDX_W'(1)) : '0;
    next_entry_c = (tbl_we_c && (load_index == rd_idx_c)) ? ld_entry_c : tbl_rd_c;
    clamp_cnt_c  = (req_count > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : req_count;
    last_c       = ({1'b0, ptr} == (count - (IDX_W+1)'(1)));
    accept_c     = (state == S_ACTIVE) && req_valid && done;
    mismatch_c   = !read_write && cur_check && (read_data != cur_expect);
  end

  cpu_seq_table #(
    .DEPTH   (DEPTH),
    .IDX_W   (IDX_W),
    .ENTRY_W (ENTRY_W)
  ) u_table (
    .clock    (clock),
    .wr_en    (tbl_we_c),
    .wr_index (load_index),
    .wr_entry (ld_entry_c),
    .rd_index (rd_idx_c),
    .rd_entry (tbl_rd_c)
  );

  // Run control FSM with registered request outputs, watchdog and saturating statistics
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      ptr            <= '0;
      count          <= '0;
      wd             <= '0;
      req_valid      <= 1'b0;
      busy           <= 1'b0;
      finished       <= 1'b0;
      timed_out      <= 1'b0;
      read_write     <= 1'b0;
      address        <= '0;
      write_data     <= '0;
      cur_check      <= 1'b0;
      cur_expect     <= '0;
      hit_count      <= '0;
      miss_count     <= '0;
      mismatch_count <= '0;
    end else begin
      case (state)
        S_ACTIVE: begin
          if (accept_c) begin
            wd <= '0;
            if (hit) begin
              if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
            end else begin
              if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            end
            if (mismatch_c && (mismatch_count != '1)) begin
              mismatch_count <= mismatch_count + CNT_W'(1);
            end
            if (last_c) begin
              state     <= S_FINISH;
              req_valid <= 1'b0;
              busy      <= 1'b0;
              finished  <= 1'b1;
            end else begin
              ptr        <= ptr + IDX_W'(1);
              read_write <= next_entry_c.read_write;
              address    <= next_entry_c.address;
              write_data <= next_entry_c.read_write ? next_entry_c.data : '0;
              cur_check  <= next_entry_c.check;
              cur_expect <= next_entry_c.data;
            end
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            // ptr and request outputs hold so the stuck request stays visible
            state     <= S_TIMEOUT;
            req_valid <= 1'b0;
            busy      <= 1'b0;
            timed_out <= 1'b1;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        S_IDLE, S_FINISH, S_TIMEOUT: begin
          if (start) begin
            count          <= clamp_cnt_c;
            ptr            <= '0;
            wd             <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
            mismatch_count <= '0;
            timed_out      <= 1'b0;
            if (clamp_cnt_c == '0) begin
              state     <= S_FINISH;
              finished  <= 1'b1;
              req_valid <= 1'b0;
              busy      <= 1'b0;
            end else begin
              state      <= S_ACTIVE;
              finished   <= 1'b0;
              req_valid  <= 1'b1;
              busy       <= 1'b1;
              read_write <= next_entry_c.read_write;
              address    <= next_entry_c.address;
              write_data <= next_entry_c.read_write ? next_entry_c.data : '0;
              cur_check  <= next_entry_c.check;
              cur_expect <= next_entry_c.data;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpu_request_sequencer.md
# cpu_request_sequencer

Programmable request generator that stands in for the processor when exercising the cache/memory hierarchy. It holds a table of up to DEPTH read/write requests loaded through a side port and issues them one at a time to the cache. It advances on each completion and counts hits, misses and read-data mismatches. A per-request watchdog catches a hung cache. It replaces the fixed, unclocked request list with a resettable, handshaked, parametrised block.

## Interface
- ADDR_W, 14, byte address width
- DATA_W, 32, write/read data width
- DEPTH, 16, request table entries; IDX_W = $clog2(DEPTH)
- TIMEOUT, 64, max cycles a request may stay outstanding
- CNT_W, 16, statistics counter width

- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- load_en  in  1  write table entry load_index
- load_index  in  IDX_W  table entry to write
- load_read_write  in  1  0 = read, 1 = write
- load_address  in  ADDR_W  request address
- load_data  in  DATA_W  write data, or expected data for reads
- load_check  in  1  compare read data against load_data
- start  in  1  begin a run (one-cycle pulse)
- req_count  in  IDX_W+1  requests in the run, 0..DEPTH
- req_valid  out  1  request presented to cache
- read_write  out  1  current request type
- address  out  ADDR_W  current request address
- write_data  out  DATA_W  current write data (0 for reads)
- done  in  1  cache completes current request this cycle
- hit  in  1  qualifies done: 1 = hit, 0 = miss
- read_data  in  DATA_W  valid with done on reads
- busy, finished, timed_out  out  1 each  status
- hit_count, miss_count, mismatch_count  out  CNT_W each  statistics

## Operation
- States: IDLE, ACTIVE, FINISH, TIMEOUT.
- Reset: state IDLE; ptr 0; all counters 0; req_valid, busy, finished and timed_out 0; address, write_data and read_write 0. Table contents are not reset.
- IDLE, FINISH and TIMEOUT accept load_en. ACTIVE ignores load_en, so the table is frozen during a run.
- start in IDLE, FINISH or TIMEOUT:
  - Latch req_count and clear ptr, the three counters, finished and timed_out.
  - If req_count == 0, go to FINISH. Otherwise go to ACTIVE.
- start in ACTIVE is ignored. req_count > DEPTH is clamped to DEPTH.
- ACTIVE:
  - req_valid = 1; busy = 1.
  - read_write, address and write_data come from the table entry at ptr.
  - done is only honoured while req_valid = 1.
- On done in ACTIVE:
  - Increment hit_count if hit = 1, else miss_count.
  - If the request is a read with check = 1 and read_data != expected, increment mismatch_count.
  - All counters saturate at 2^CNT_W-1.
  - Clear the watchdog. If ptr == count-1, go to FINISH; otherwise increment ptr.
- Watchdog: counts ACTIVE cycles without done. On reaching TIMEOUT, go to TIMEOUT.
- TIMEOUT: req_valid = 0; timed_out = 1 and ptr are held so the stuck request index stays visible.
- FINISH: finished = 1, held until the next start.
- Reset mid-run aborts immediately. There is no partial completion.

## Timing
- start sampled at edge N → req_valid = 1 after edge N, with entry 0 on the outputs.
- done sampled at edge M:
  - Counters update after M.
  - The next request appears after M, back-to-back with no idle cycle.
  - After the last request, req_valid = 0 and finished = 1 after M.
- The request outputs are registered. They change only at an edge where done is accepted, or on start.
- Timeout: TIMEOUT consecutive ACTIVE cycles without done → timed_out = 1 on the next edge.
- A done in the same cycle as the watchdog expiry wins: the request completes and there is no timeout.
- load_en and start in the same cycle from IDLE: the load is written and the run starts. Entry writes take effect on the next edge.

## Structure
- Package cpu_seq_pkg holds:
  - the state enum (IDLE/ACTIVE/FINISH/TIMEOUT);
  - default ADDR_W, DATA_W and CNT_W;
  - a packed request struct {read_write, check, address, data}.
- Sub-module cpu_seq_table is the DEPTH-entry request storage: one write port (load) and one asynchronous read port (ptr).
- Top level contains the FSM, ptr, watchdog and the saturating counters.

## Test plan
- Basic run: load 3 entries (read 0x06A9 expect 0xAC chk; write 0x06A1 data 0xAC; read 0x03C8 no chk). Cache answers done after 2 cycles with hit = 0,1,1 → hit_count 2, miss_count 1, mismatch_count 0, finished = 1.
- Mismatch: read entry expecting 0xFFFFFFAC, cache returns 0xAABBCCDD → mismatch_count 1; the same with check = 0 → 0.
- Back-to-back: done held high for 4 cycles on a 4-entry run → 4 consecutive addresses, one per cycle; finished 1 cycle after the last done.
- Timeout: TIMEOUT = 8, cache never asserts done on entry 2 → timed_out after 8 ACTIVE cycles, ptr = 2, req_valid = 0. The next start clears the stats.
- Edge cases:
  - req_count = 0 → finished with no req_valid.
  - req_count = DEPTH+3 → exactly DEPTH requests.
  - load_en during ACTIVE does not alter the issued data.
  - reset asserted mid-run → all outputs 0 immediately.
- Saturation: CNT_W = 2, 5 hits → hit_count = 3.
